// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Holds the arbiter state enum and the default parameter constants.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_MAX_DEF = 4;

    // Index width that stays legal for a single producer
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin pick: first requester after last_owner, wrapping.
// Purely combinational; hit is low when no request is pending.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic               hit,
    output logic [IW-1:0]      index
);

    int            c;
    logic [IW-1:0] ci;

    // Scan candidates last_owner+1 .. last_owner+NUM_REQ; first hit wins
    always_comb begin
        hit   = 1'b0;
        index = '0;
        c     = 0;
        ci    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(last_owner) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            ci = IW'(c);
            if (!hit && req[ci]) begin
                hit   = 1'b1;
                index = ci;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Optional FIFO_WR_ARB_HF_THROTTLE_EN: no new grant while fifo_hf=1.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int BURST_MAX = BURST_MAX_DEF,
    localparam int IW        = idx_w(NUM_REQ),
    localparam int CW        = $clog2(BURST_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_full,
    input  logic                      fifo_hf,
    output logic [IW-1:0]             grant_id,
    output logic                      busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
    localparam logic [IW-1:0] OWN_INIT = IW'(NUM_REQ - 1);

    arb_state_e    state;
    arb_state_e    state_nx;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nx;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] last_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          hit;
    logic          start;
    logic          accept;
    logic          done;
    logic [IW-1:0] pick;

    fifo_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .hit        (hit),
        .index      (pick)
    );

`ifdef FIFO_WR_ARB_HF_THROTTLE_EN
    assign start = hit && !fifo_hf;
`else
    logic unused_hf;
    assign unused_hf = fifo_hf;
    assign start     = hit;
`endif

    assign grant_id = owner;

    // Next state plus zero-latency write path; reset cycle never writes
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last_owner;
        cnt_nx     = cnt;
        accept     = 1'b0;
        done       = 1'b0;
        ack        = '0;
        fifo_write = 1'b0;
        fifo_data  = '0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    owner_nx = pick;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                busy = 1'b1;
                if (!reset) begin
                    fifo_data = req_data[int'(owner)*DATA_W +: DATA_W];
                end
                accept     = req[owner] && !fifo_full && !reset;
                fifo_write = accept;
                ack[owner] = accept;
                if (accept) begin
                    cnt_nx = cnt + CW'(1);
                end
                done = !req[owner] ||
                       (accept && (req_last[owner] || cnt == CNT_LAST));
                if (done) begin
                    state_nx = IDLE;
                    last_nx  = owner;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, owner and burst bookkeeping with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OWN_INIT;
            cnt        <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            cnt        <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic,
// every cycle compared against a packet-level reference model.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int B  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      ack;
    logic              fifo_write;
    logic [W-1:0]      fifo_data;
    logic              fifo_full;
    logic              fifo_hf;
    logic [IW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ    (N),
        .DATA_W     (W),
        .BURST_MAX  (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .fifo_hf    (fifo_hf),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // reference model: who holds the port and how many words so far
    bit            m_gnt;
    logic [IW-1:0] m_own;
    logic [IW-1:0] m_prev;
    int            m_cnt;

    int left[N];
    int dwr;
    int dlog[$];
    bit rnd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        fifo_hf   = 1'b0;
        for (int i = 0; i < N; i++) left[i] = 0;
    endtask

    task automatic start_pkt(input int i, input int len);
        left[i]           = len;
        req[i]            = 1'b1;
        req_last[i]       = (len == 1);
        req_data[i*W +: W] = W'($urandom);
    endtask

    task automatic tick();
        logic          e_wr;
        logic [N-1:0]  e_ack;
        logic [W-1:0]  e_dat;
        logic [IW-1:0] a;
        logic [IW-1:0] c;
        bit            hfb;
        bit            found;
        @(negedge clk);
        e_wr  = m_gnt && !reset && req[m_own] && !fifo_full;
        e_ack = '0;
        if (e_wr) e_ack[m_own] = 1'b1;
        e_dat = (m_gnt && !reset) ? req_data[m_own*W +: W] : '0;
        chk("write", 32'(fifo_write), 32'(e_wr));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("data", 32'(fifo_data), 32'(e_dat));
        chk("busy", 32'(busy), 32'(m_gnt));
        chk("grant_id", 32'(grant_id), 32'(m_own));
        if (fifo_write === 1'b1) begin
            dwr++;
            dlog.push_back(int'(grant_id));
        end
        a = m_own;
        @(posedge clk);
        if (reset) begin
            m_gnt  = 1'b0;
            m_own  = '0;
            m_prev = IW'(N - 1);
            m_cnt  = 0;
        end else if (!m_gnt) begin
            hfb = 1'b0;
`ifdef FIFO_WR_ARB_HF_THROTTLE_EN
            hfb = fifo_hf;
`endif
            if (req != '0 && !hfb) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = IW'((int'(m_prev) + k) % N);
                    if (!found && req[c]) begin
                        m_own = c;
                        found = 1'b1;
                    end
                end
                m_gnt = 1'b1;
            end
        end else begin
            if (e_wr) m_cnt++;
            if (!req[m_own] || (e_wr && (req_last[m_own] || m_cnt == B))) begin
                m_gnt  = 1'b0;
                m_prev = m_own;
                m_cnt  = 0;
            end
        end
        #1;
        if (e_wr) begin
            left[a]--;
            req_data[a*W +: W] = W'($urandom);
            req_last[a]        = (left[a] == 1);
            if (left[a] <= 0) req[a] = 1'b0;
        end
        if (rnd) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            fifo_hf   = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    start_pkt(i, int'($urandom_range(1, 6)));
                end else if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i]      = 1'b0;
                    req_last[i] = 1'b0;
                    left[i]     = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        rnd      = 1'b0;
        req_data = '0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        m_gnt  = 1'b0;
        m_own  = '0;
        m_prev = IW'(N - 1);
        m_cnt  = 0;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(fifo_write), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);

        // all four streaming, no packet ends: 0,1,2,3,0 with 4 words each
        for (int i = 0; i < N; i++) start_pkt(i, 1000);
        dwr = 0;
        dlog.delete();
        repeat (25) tick();
        chk("s1_writes", 32'(dwr), 32'd20);
        for (int j = 0; j < dlog.size(); j++) begin
            chk("s1_owner", 32'(dlog[j]), 32'((j / 4) % 4));
        end

        // producer 2 alone, two-word packet
        do_reset();
        start_pkt(2, 2);
        dwr = 0;
        dlog.delete();
        repeat (6) tick();
        chk("s2_writes", 32'(dwr), 32'd2);
        for (int j = 0; j < dlog.size(); j++) begin
            chk("s2_owner", 32'(dlog[j]), 32'd2);
        end
        chk("s2_idle", 32'(busy), 32'd0);

        // FIFO full for three cycles mid-burst
        do_reset();
        start_pkt(0, 1000);
        dwr = 0;
        repeat (2) tick();
        fifo_full = 1'b1;
        n0 = dwr;
        repeat (3) tick();
        chk("s3_stall", 32'(dwr), 32'(n0));
        chk("s3_held", 32'(busy), 32'd1);
        fifo_full = 1'b0;
        repeat (3) tick();
        chk("s3_burst", 32'(dwr), 32'd4);
        chk("s3_exit", 32'(busy), 32'd0);

        // reset during owner 1's second word
        do_reset();
        start_pkt(1, 1000);
        dwr = 0;
        repeat (2) tick();
        chk("s4_first", 32'(dwr), 32'd1);
        reset = 1'b1;
        tick();
        chk("s4_rst_nowr", 32'(dwr), 32'd1);
        reset = 1'b0;
        idle_inputs();
        start_pkt(0, 1000);
        start_pkt(1, 1000);
        tick();
        chk("s4_owner", 32'(grant_id), 32'd0);
        chk("s4_busy", 32'(busy), 32'd1);

`ifdef FIFO_WR_ARB_HF_THROTTLE_EN
        // half-full blocks new grants only
        do_reset();
        fifo_hf = 1'b1;
        start_pkt(0, 1000);
        repeat (3) tick();
        chk("s5_hold", 32'(busy), 32'd0);
        fifo_hf = 1'b0;
        tick();
        chk("s5_busy", 32'(busy), 32'd1);
        chk("s5_owner", 32'(grant_id), 32'd0);
`endif

        // owner 0 drops its request after one word
        do_reset();
        start_pkt(0, 1000);
        start_pkt(1, 1000);
        repeat (2) tick();
        req[0] = 1'b0;
        dwr = 0;
        dlog.delete();
        repeat (3) tick();
        chk("s6_writes", 32'(dwr), 32'd1);
        for (int j = 0; j < dlog.size(); j++) begin
            chk("s6_owner", 32'(dlog[j]), 32'd1);
        end

        // random traffic
        do_reset();
        rnd = 1'b1;
        repeat (3000) tick();
        rnd = 1'b0;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of producers sharing one FIFO write port.
REQ-002 The block SHALL have parameter DATA_W, default 8, word width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, maximum words accepted per grant before rotating.
REQ-004 The block SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port req  input  NUM_REQ  per-producer word-valid.
REQ-007 The block SHALL have port req_data  input  NUM_REQ*DATA_W  producer words; producer i occupies bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_last  input  NUM_REQ  marks the final word of a producer's packet.
REQ-009 The block SHALL have port ack  output  NUM_REQ  one-hot word-accepted strobe.
REQ-010 The block SHALL have port fifo_write  output  1  FIFO write strobe.
REQ-011 The block SHALL have port fifo_data  output  DATA_W  FIFO write data.
REQ-012 The block SHALL have ports fifo_full and fifo_hf  input  1 each  FIFO status flags.
REQ-013 The block SHALL have port grant_id  output  clog2(NUM_REQ)  current owner; port busy  output  1  high in GRANT.

Function
REQ-014 The block SHALL implement states IDLE and GRANT.
REQ-015 IDLE: if any req bit is high, the block SHALL register the owner by round-robin search starting at last_owner+1 (wrapping), then enter GRANT next cycle.
REQ-016 GRANT: accept = req[owner] && !fifo_full; fifo_write, ack[owner] and fifo_data = req_data[owner] SHALL be combinational, with zero latency, in the same cycle.
REQ-017 The producer SHALL hold req_data and req_last stable until ack; a word advances only on ack.
REQ-018 burst_cnt SHALL increment on each accept; GRANT->IDLE on an accept with req_last=1, an accept making burst_cnt==BURST_MAX, or req[owner]=0; on exit, last_owner <= owner and burst_cnt <= 0.
REQ-019 With fifo_full=1 in GRANT, the block SHALL stall: no write, no ack, and the state and burst_cnt held.
REQ-020 The block SHALL idle for at least one cycle between grants; maximum throughput is BURST_MAX words per BURST_MAX+1 cycles.
REQ-021 Outside GRANT, ack, fifo_write and busy SHALL be 0; fifo_data SHALL be 0.
REQ-022 req bits of non-owners SHALL be ignored during GRANT.

Reset
REQ-023 Reset SHALL set state IDLE, burst_cnt 0, grant_id 0, and last_owner NUM_REQ-1, so producer 0 wins first; all outputs SHALL be 0 in the following cycle.
REQ-024 Reset asserted mid-burst SHALL abort the grant with no write in the reset cycle; the partial packet is the producer's responsibility.

Configuration
REQ-025 With FIFO_WR_ARB_HF_THROTTLE_EN defined, IDLE SHALL not issue a grant while fifo_hf=1, and an in-progress GRANT SHALL continue; without it, fifo_hf SHALL be ignored.

Structure
REQ-026 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default NUM_REQ, DATA_W and BURST_MAX constants.
REQ-027 The round-robin search SHALL be sub-module fifo_rr_pick: inputs req and last_owner, outputs hit and index; purely combinational.

Verification
REQ-028 The bench SHALL cover: reset, then req=4'b1111 with all req_last=0 -> owners 0,1,2,3,0 in order, 4 writes each, one idle cycle between grants.
REQ-029 The bench SHALL cover: req[2] only, req_last on the 2nd word -> exactly 2 writes, ack=4'b0100 twice, then IDLE.
REQ-030 The bench SHALL cover: fifo_full=1 for 3 cycles mid-burst -> no fifo_write or ack for 3 cycles, then burst resumes and total words per grant stay 4.
REQ-031 The bench SHALL cover: reset asserted during the 2nd word of owner 1 -> no write in the reset cycle; next grant goes to producer 0 when req=4'b0011.
REQ-032 The bench SHALL cover: with FIFO_WR_ARB_HF_THROTTLE_EN, fifo_hf=1 while req=4'b0001 -> busy stays 0; fifo_hf falls -> grant to producer 0 after 1 cycle.
REQ-033 The bench SHALL cover: req[owner] drops after 1 word with NUM_REQ=4 -> grant released, next requester served, no write of stale data.
